fb_scroll_arbiter: RTL

- Shares one single-port pixel RAM between two requesters.
  - Display pixel reader: driven by the LCD timing block at most once per 3 clocks (8-bit serial RGB, 3 clocks/pixel).
  - Waterfall line writer.
- Display reads always win; the writer gets the free cycles.
- Maps display rows through a scroll offset so the waterfall scrolls without copying RAM. New offsets take effect only at frame start, so there is no tearing.
- Sits between the video timing block, the spectrum/waterfall writer and the frame RAM.

---
 rtl/fb_scroll_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/fb_scroll_arbiter.sv
// fb_scroll_arbiter: shares one single-port frame RAM between the display
// pixel reader (always wins) and the waterfall line writer (free cycles).
// Display rows are remapped through a scroll offset latched at frame start.
// Optional writer stall counter: define FB_STALL_CNT_EN.
module fb_scroll_arbiter #(
  parameter int H_VISIBLE = 320,
  parameter int V_VISIBLE = 240,
  parameter int ADDR_W    = 17,
  parameter int DATA_W    = 24
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              frame_start,
  input  logic              disp_req,
  input  logic [8:0]        disp_x,
  input  logic [7:0]        disp_y,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              wr_req,
  input  logic [8:0]        wr_col,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              line_done,
  output logic [7:0]        wr_row,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stall_cnt
);

  // address register + RAM read
  localparam int STAGES = 2;

  localparam logic [9:0] H_LIM    = 10'(H_VISIBLE);
  localparam logic [8:0] V_LIM    = 9'(V_VISIBLE);
  localparam logic [7:0] ROW_LAST = 8'(V_VISIBLE - 1);

  logic [7:0]        pend_scroll, scroll;
  logic [8:0]        row_sum;
  logic [7:0]        phys_row;
  logic              disp_ok, wr_ok;
  logic [ADDR_W-1:0] disp_addr, wr_addr;
  logic [STAGES-1:0] vld_pipe, ok_pipe;
  logic [DATA_W-1:0] rdata_hold;

  // row*H_VISIBLE + col; constant multiply folds to shift-add
  function automatic logic [ADDR_W-1:0] pix_addr(input logic [7:0] row,
                                                 input logic [8:0] col);
    pix_addr = ADDR_W'(32'(row) * 32'(H_VISIBLE) + 32'(col));
  endfunction

  // scroll mapping by compare-subtract: both operands < V_VISIBLE, so one
  // subtraction is always enough
  always_comb begin
    row_sum  = {1'b0, disp_y} + {1'b0, scroll};
    phys_row = row_sum[7:0];
    if (row_sum >= V_LIM) phys_row = 8'(row_sum - V_LIM);
  end

  assign disp_ok   = ({1'b0, disp_x} < H_LIM) && ({1'b0, disp_y} < V_LIM);
  assign wr_ok     = ({1'b0, wr_col} < H_LIM);
  assign disp_addr = pix_addr(phys_row, disp_x);
  assign wr_addr   = pix_addr(pend_scroll, wr_col);

  // writer is granted whenever the display is idle; an out-of-range column
  // still gets its ack so the writer never hangs. Held low in reset.
  assign wr_ack = resetn & wr_req & ~disp_req;
  assign wr_row = pend_scroll;

  // scroll bookkeeping: writer row advances per line, display picks it up
  // only at frame start (pre-increment value when both coincide)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_scroll <= '0;
      scroll      <= '0;
    end else begin
      if (frame_start) scroll <= pend_scroll;
      if (line_done)   pend_scroll <= (pend_scroll == ROW_LAST) ? 8'd0 : pend_scroll + 8'd1;
    end
  end

  // registered RAM port; address holds when nothing in range is granted
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_addr  <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
    end else if (disp_req) begin
      mem_we <= 1'b0;
      if (disp_ok) mem_addr <= disp_addr;
    end else if (wr_req) begin
      mem_we <= wr_ok;
      if (wr_ok) begin
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end
    end else begin
      mem_we <= 1'b0;
    end
  end

  // read valid pipeline; the in-range flag rides along to zero bad reads
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vld_pipe <= '0;
      ok_pipe  <= '0;
    end else begin
      vld_pipe <= {vld_pipe[STAGES-2:0], disp_req};
      ok_pipe  <= {ok_pipe[STAGES-2:0], disp_req & disp_ok};
    end
  end

  assign disp_rvalid = vld_pipe[STAGES-1];

  // RAM data is passed through during the valid pulse, held afterwards
  always_comb begin
    disp_rdata = rdata_hold;
    if (disp_rvalid) disp_rdata = ok_pipe[STAGES-1] ? mem_rdata : '0;
  end

  // capture the presented pixel so it stays stable between pulses
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) rdata_hold <= '0;
    else         rdata_hold <= disp_rdata;
  end

`ifdef FB_STALL_CNT_EN
  logic [15:0] stall_q;

  // count writer stalls per frame, saturating; frame start clear wins
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                        stall_q <= '0;
    else if (frame_start)                               stall_q <= '0;
    else if (wr_req && !wr_ack && stall_q != 16'hFFFF)  stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule
